// File: rtl/memory_mapped_io_uart_rx.sv
// 8N1 UART receiver that deposits bytes into a 256-entry ring buffer.
// The receiver advances queue_tail; the consumer reads through rd_addr and owns queue_head.
module memory_mapped_io_uart_rx #(
    parameter int CLK_FREQ  = 27000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    input  logic [7:0] queue_head,
    output logic [7:0] queue_tail,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       overrun,
    output logic       frame_err,
    input  logic       err_clear,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             sync1_reg, rx_s_reg;
    logic [7:0]       tail_reg;
    logic             overrun_reg, frame_err_reg;
    logic [7:0]       rd_data_reg;
    logic [7:0]       mem [0:255];

    logic full;
    logic do_write, set_overrun, set_frame_err, sample_data, start_data;

    assign full = (tail_reg + 8'd1) == queue_head;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            rx_s_reg  <= 1'b1;
        end else begin
            sync1_reg <= uart_rx;
            rx_s_reg  <= sync1_reg;
        end
    end

    always_comb begin
        state_next    = state_reg;
        do_write      = 1'b0;
        set_overrun   = 1'b0;
        set_frame_err = 1'b0;
        sample_data   = 1'b0;
        start_data    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_s_reg) state_next = START;
            end
            START: begin
                if (cnt_reg == HALF_LAST) begin
                    if (rx_s_reg) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        start_data = 1'b1;
                    end
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    sample_data = 1'b1;
                    if (bit_idx_reg == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                // Leave mid stop bit so a back-to-back start edge is not missed.
                if (cnt_reg == BIT_LAST) begin
                    state_next = IDLE;
                    if (!rx_s_reg)  set_frame_err = 1'b1;
                    else if (full)  set_overrun   = 1'b1;
                    else            do_write      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= 3'd0;
            shift_reg     <= 8'd0;
            tail_reg      <= 8'd0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg || state_reg == IDLE) cnt_reg <= '0;
            else                                              cnt_reg <= cnt_reg + 1'b1;

            if (start_data) begin
                bit_idx_reg <= 3'd0;
            end else if (sample_data) begin
                shift_reg[bit_idx_reg] <= rx_s_reg;
                bit_idx_reg            <= bit_idx_reg + 3'd1;
            end

            if (do_write) tail_reg <= tail_reg + 8'd1;

            // A new error event beats a simultaneous clear.
            if (set_overrun)    overrun_reg <= 1'b1;
            else if (err_clear) overrun_reg <= 1'b0;

            if (set_frame_err)  frame_err_reg <= 1'b1;
            else if (err_clear) frame_err_reg <= 1'b0;
        end
    end

    // Buffer storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_write) mem[tail_reg] <= shift_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_reg <= 8'd0;
        else        rd_data_reg <= mem[rd_addr];
    end

    assign queue_tail = tail_reg;
    assign rd_data    = rd_data_reg;
    assign overrun    = overrun_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_memory_mapped_io_uart_rx.sv
// Bench for memory_mapped_io_uart_rx at 16 clocks per bit: directed table, latency,
// glitch, framing, full/wrap, mid-frame reset and randomized frames against a ring-buffer model.
module tb_memory_mapped_io_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic [7:0] queue_head;
    logic [7:0] queue_tail;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       overrun;
    logic       frame_err;
    logic       err_clear;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ring buffer contents, producer pointer and sticky flags.
    logic [7:0] m_mem [256];
    logic [7:0] m_tail;
    logic       m_ferr, m_ovr;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic [7:0] exp_tail;
        logic       exp_ferr;
    } vec_t;
    vec_t vec [4];

    memory_mapped_io_uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .queue_head (queue_head),
        .queue_tail (queue_tail),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .err_clear  (err_clear),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic model_frame(input logic [7:0] data, input logic stop);
        if (!stop)                               m_ferr = 1'b1;
        else if (8'(m_tail + 8'd1) == queue_head) m_ovr = 1'b1;
        else begin
            m_mem[m_tail] = data;
            m_tail        = m_tail + 8'd1;
        end
    endtask

    // Drives one complete frame starting right after a clock edge; returns the line high.
    task automatic send_frame(input logic [7:0] data, input logic stop);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            tick(CPB);
        end
        uart_rx = stop;
        tick(CPB);
        uart_rx = 1'b1;
        model_frame(data, stop);
    endtask

    task automatic read_buf(input logic [7:0] addr, output logic [7:0] val);
        rd_addr = addr;
        tick(1);
        val = rd_data;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        m_tail = 8'd0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        uart_rx = 1'b1;
        tick(40);
    endtask

    initial begin
        logic [7:0] rv;
        logic [7:0] b;
        logic       st;
        logic [7:0] addr;

        rst_n = 1'b0; uart_rx = 1'b1; queue_head = 8'd0; rd_addr = 8'd0; err_clear = 1'b0;
        m_tail = 8'd0; m_ferr = 1'b0; m_ovr = 1'b0;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'hxx;

        tick(3);
        check("reset_tail", queue_tail, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_flags", {overrun, frame_err}, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        tick(40);

        // Single byte with exact write latency measured from the first edge that sees the start bit.
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(posedge clk);
                repeat (153) @(posedge clk);
                #1 check("latency_before", queue_tail, 0);
                @(posedge clk);
                #1 check("latency_at", queue_tail, 1);
            end
        join
        tick(4);
        read_buf(8'd0, rv);
        check("single_rd_data", rv, 8'hA5);
        check("single_flags", {overrun, frame_err}, 0);

        // Back-to-back frames followed by a framing error.
        vec[0] = '{8'h00, 1'b1, 0,  8'd2, 1'b0};
        vec[1] = '{8'hFF, 1'b1, 0,  8'd3, 1'b0};
        vec[2] = '{8'h3C, 1'b1, 40, 8'd4, 1'b0};
        vec[3] = '{8'h55, 1'b0, 40, 8'd4, 1'b1};
        for (int i = 0; i < 4; i++) begin
            send_frame(vec[i].data, vec[i].stop);
            tick(vec[i].gap);
            check($sformatf("vec%0d_tail", i), queue_tail, vec[i].exp_tail);
            check($sformatf("vec%0d_ferr", i), frame_err, vec[i].exp_ferr);
        end
        for (int i = 0; i < 3; i++) begin
            read_buf(8'(i + 1), rv);
            check($sformatf("b2b_buf%0d", i + 1), rv, vec[i].data);
        end
        check("ferr_no_overrun", overrun, 0);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        check("ferr_cleared", frame_err, 0);
        m_ferr = 1'b0;

        // Four-cycle glitch must be rejected.
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        check("glitch_busy_high", busy, 1);
        tick(8);
        check("glitch_busy_low", busy, 0);
        check("glitch_tail", queue_tail, 4);
        check("glitch_flags", {overrun, frame_err}, 0);

        // Fill from an empty buffer: 255 bytes fit, the 256th overruns.
        do_reset();
        queue_head = 8'd0;
        for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1);
        tick(4);
        check("full_tail", queue_tail, 255);
        check("full_overrun", overrun, 1);
        check("full_ferr", frame_err, 0);
        queue_head = 8'd200;
        send_frame(8'h77, 1'b1);
        tick(4);
        check("wrap_tail", queue_tail, 0);
        read_buf(8'd255, rv);
        check("wrap_buf255", rv, 8'h77);
        read_buf(8'd254, rv);
        check("wrap_buf254", rv, 8'hFE);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        m_ovr = 1'b0;
        check("ovr_cleared", overrun, 0);

        // Randomized frames, head positions and stop bits against the model.
        for (int n = 0; n < 40; n++) begin
            b  = 8'($urandom);
            st = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0:       queue_head = 8'(m_tail + 8'd1);
                1:       queue_head = m_tail;
                default: queue_head = 8'($urandom);
            endcase
            if ($urandom_range(0, 4) == 0) begin
                err_clear = 1'b1;
                tick(1);
                err_clear = 1'b0;
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end
            send_frame(b, st);
            tick(st ? $urandom_range(2, 6) : 30);
            check($sformatf("rnd%0d_tail", n), queue_tail, m_tail);
            check($sformatf("rnd%0d_flags", n), {overrun, frame_err}, {m_ovr, m_ferr});
            addr = 8'(m_tail - 8'd1);
            read_buf(addr, rv);
            check($sformatf("rnd%0d_buf%0d", n, addr), rv, m_mem[addr]);
        end

        // Reset during data bit 4 aborts the frame.
        queue_head = 8'd0;
        if (queue_tail == 8'd0) begin
            send_frame(8'h11, 1'b1);
            tick(4);
        end
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            uart_rx = 1'(i % 2);
            tick(CPB);
        end
        uart_rx = 1'b1;
        tick(CPB / 2);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_tail", queue_tail, 0);
        tick(2);
        rst_n = 1'b1;
        m_tail = 8'd0; m_ferr = 1'b0; m_ovr = 1'b0;
        tick(40);
        send_frame(8'h81, 1'b1);
        tick(4);
        check("midrst_after_tail", queue_tail, 1);
        read_buf(8'd0, rv);
        check("midrst_buf0", rv, 8'h81);
        check("midrst_flags", {overrun, frame_err}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
